// File: rtl/move_scheduler_if.sv
// ----------------------------------------------------------------------------
// move_scheduler_if
//   Command handshake between the move scheduler and the game-logic core.
//
//   Signals:
//     cmd_valid  scheduler -> core   a command is present
//     cmd        scheduler -> core   3-bit command code, 0 when idle
//     cmd_ready  core -> scheduler   core accepts the command this cycle
//
//   Modports:
//     master  the scheduler (drives cmd_valid/cmd, samples cmd_ready)
//     slave   the game core (samples cmd_valid/cmd, drives cmd_ready)
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps

interface move_scheduler_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        output cmd_ready
    );
endinterface

// File: rtl/move_scheduler.sv
// ----------------------------------------------------------------------------
// move_scheduler
//   Turns key levels (left/right/up/down) and an internal gravity timer into a
//   serialized stream of single move commands on a valid/ready handshake.
//   Exactly one command is offered at a time; issue stops for good once the
//   game core reports failure, until the next reset.
//
//   Command codes: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFT_DROP, 5 GRAVITY, 0 idle.
//   Priority when a command is picked: GRAVITY > ROTATE > LEFT > RIGHT >
//   SOFT_DROP. The picked command is frozen until it is accepted.
//
//   Ports:
//     clk      in   system clock
//     clrn     in   asynchronous active-low reset
//     left     in   key level, move left
//     right    in   key level, move right
//     up       in   key level, rotate
//     down     in   key level, soft drop
//     level    in   difficulty level 0..15, shortens the gravity period
//     fail     in   game-over flag from the game core
//     cmd_if   master side of the command handshake (cmd_valid/cmd/cmd_ready)
//     halted   out  high once fail has been seen
//
//   Build option:
//     AUTOREPEAT_EN  when defined, holding left/right/down re-issues the move
//                    after DAS_DELAY cycles and then every DAS_RATE cycles.
//                    When undefined, commands come from rising edges only.
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps

module move_scheduler #(
    parameter int unsigned GRAV_BASE = 50000000,
    parameter int unsigned GRAV_STEP = 2500000,
    parameter int unsigned GRAV_MIN  = 5000000,
    parameter int unsigned DAS_DELAY = 20000000,
    parameter int unsigned DAS_RATE  = 5000000,
    parameter int unsigned CNT_W     = 27
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                left,
    input  logic                right,
    input  logic                up,
    input  logic                down,
    input  logic [3:0]          level,
    input  logic                fail,
    move_scheduler_if.master    cmd_if,
    output logic                halted
);

    // Period arithmetic is done 4 bits wider than the counter so that
    // level * GRAV_STEP can exceed GRAV_BASE without wrapping.
    localparam int unsigned PW = CNT_W + 4;

    localparam logic [2:0] CmdNone   = 3'd0;
    localparam logic [2:0] CmdLeft   = 3'd1;
    localparam logic [2:0] CmdRight  = 3'd2;
    localparam logic [2:0] CmdRotate = 3'd3;
    localparam logic [2:0] CmdSoft   = 3'd4;
    localparam logic [2:0] CmdGrav   = 3'd5;

    // Pending flag bit i belongs to command code i+1.
    localparam int unsigned NumCmd = 5;

    // Reject parameter sets the counters cannot represent.
    if ((GRAV_BASE >> CNT_W) != 0 || (DAS_DELAY >> CNT_W) != 0 || GRAV_MIN == 0 ||
        DAS_RATE == 0 || DAS_RATE > DAS_DELAY) begin : g_param_check
        $error("move_scheduler: CNT_W too small or invalid gravity/DAS parameters");
    end

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [NumCmd-1:0] pend_q, pend_d;
    logic [NumCmd-1:0] set_v;
    logic              left_q, right_q, up_q, down_q;
    logic [CNT_W-1:0]  grav_cnt_q, grav_cnt_d;

    logic              accept;
    logic              rise_left, rise_right, rise_up, rise_down;
    logic              rep_left, rep_right, rep_down;
    logic [PW-1:0]     grav_reduce, grav_period;
    logic              grav_wrap;
    logic              soft_accept;

    // ------------------------------------------------------------------------
    // Key edge detection
    // ------------------------------------------------------------------------
    assign rise_left  = left  & ~left_q;
    assign rise_right = right & ~right_q;
    assign rise_up    = up    & ~up_q;
    assign rise_down  = down  & ~down_q;

    // ------------------------------------------------------------------------
    // Optional auto-repeat for left/right/down
    // ------------------------------------------------------------------------
`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DasTop    = CNT_W'(DAS_DELAY - 1);
    // Reloading to DasTop - DAS_RATE + 1 makes later repeats DAS_RATE apart.
    localparam logic [CNT_W-1:0] DasReload = CNT_W'(DAS_DELAY - DAS_RATE);

    logic [2:0]            hold_keys;
    logic [2:0][CNT_W-1:0] hold_q, hold_d;
    logic [2:0]            hold_fire;

    assign hold_keys = {down, right, left};

    always_comb begin
        hold_d    = hold_q;
        hold_fire = '0;
        for (int i = 0; i < 3; i++) begin
            if (!hold_keys[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] == DasTop) begin
                hold_fire[i] = 1'b1;
                hold_d[i]    = DasReload;
            end else begin
                hold_d[i] = hold_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Holding both horizontal keys suppresses horizontal repeat entirely.
    assign rep_left  = hold_fire[0] & ~right;
    assign rep_right = hold_fire[1] & ~left;
    assign rep_down  = hold_fire[2];
`else
    assign rep_left  = 1'b0;
    assign rep_right = 1'b0;
    assign rep_down  = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Gravity timer
    // ------------------------------------------------------------------------
    always_comb begin
        grav_reduce = PW'(level) * PW'(GRAV_STEP);
        if (grav_reduce >= PW'(GRAV_BASE) ||
            (PW'(GRAV_BASE) - grav_reduce) < PW'(GRAV_MIN)) begin
            grav_period = PW'(GRAV_MIN);
        end else begin
            grav_period = PW'(GRAV_BASE) - grav_reduce;
        end
    end

    // count >= period-1, written without the subtraction; the >= lets a
    // period shortened mid-count wrap on the very next cycle.
    assign grav_wrap   = (PW'(grav_cnt_q) + PW'(1)) >= grav_period;
    assign soft_accept = accept && (cmd_q == CmdSoft);

    always_comb begin
        if (grav_wrap || soft_accept) begin
            grav_cnt_d = '0;
        end else begin
            grav_cnt_d = grav_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Pending flags
    // ------------------------------------------------------------------------
    always_comb begin
        set_v    = '0;
        // Simultaneous left and right edges cancel each other.
        set_v[0] = (rise_left & ~rise_right) | rep_left;
        set_v[1] = (rise_right & ~rise_left) | rep_right;
        set_v[2] = rise_up;
        set_v[3] = rise_down | rep_down;
        set_v[4] = grav_wrap;

        pend_d = pend_q;
        for (int i = 0; i < NumCmd; i++) begin
            if (set_v[i]) begin
                pend_d[i] = 1'b1;
            end
            // Acceptance wins over a coincident set: events while pending are absorbed.
            if (accept && (cmd_q == 3'(i + 1))) begin
                pend_d[i] = 1'b0;
            end
        end
        if (fail || (state_q == StHalt)) begin
            pend_d = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_d = CmdNone;
                if (fail) begin
                    state_d = StHalt;
                end else if (pend_q != '0) begin
                    state_d = StIssue;
                    if (pend_q[4]) begin
                        cmd_d = CmdGrav;
                    end else if (pend_q[2]) begin
                        cmd_d = CmdRotate;
                    end else if (pend_q[0]) begin
                        cmd_d = CmdLeft;
                    end else if (pend_q[1]) begin
                        cmd_d = CmdRight;
                    end else begin
                        cmd_d = CmdSoft;
                    end
                end
            end
            StIssue: begin
                // fail in the handshake cycle aborts the command unaccepted.
                if (fail) begin
                    state_d = StHalt;
                    cmd_d   = CmdNone;
                end else if (cmd_if.cmd_ready) begin
                    accept  = 1'b1;
                    state_d = StIdle;
                    cmd_d   = CmdNone;
                end
            end
            StHalt: begin
                cmd_d = CmdNone;
            end
            default: begin
                state_d = StIdle;
                cmd_d   = CmdNone;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= StIdle;
            cmd_q      <= CmdNone;
            pend_q     <= '0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            grav_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            pend_q     <= pend_d;
            left_q     <= left;
            right_q    <= right;
            up_q       <= up;
            down_q     <= down;
            grav_cnt_q <= grav_cnt_d;
        end
    end

    assign cmd_if.cmd_valid = (state_q == StIssue);
    assign cmd_if.cmd       = cmd_q;
    assign halted           = (state_q == StHalt);

endmodule

// File: tb/tb_move_scheduler.sv
// ----------------------------------------------------------------------------
// tb_move_scheduler
//   Directed bench for move_scheduler with GRAV_BASE=100, GRAV_STEP=10,
//   GRAV_MIN=20, DAS_DELAY=40, DAS_RATE=8. Edge numbers count rising clock
//   edges after reset release (edge 1 is the first). Outputs are sampled 1ns
//   after each edge. Command observations are packed as {cmd_valid, cmd},
//   so 0xD is a valid GRAVITY, 0x9 a valid LEFT, 0x0 idle.
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_move_scheduler;

    logic       clk   = 1'b0;
    logic       clrn  = 1'b1;
    logic       left  = 1'b0;
    logic       right = 1'b0;
    logic       up    = 1'b0;
    logic       down  = 1'b0;
    logic [3:0] level = 4'd0;
    logic       fail  = 1'b0;
    logic       halted;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    move_scheduler_if cmd_if ();

    move_scheduler #(
        .GRAV_BASE (100),
        .GRAV_STEP (10),
        .GRAV_MIN  (20),
        .DAS_DELAY (40),
        .DAS_RATE  (8),
        .CNT_W     (27)
    ) dut (
        .clk    (clk),
        .clrn   (clrn),
        .left   (left),
        .right  (right),
        .up     (up),
        .down   (down),
        .level  (level),
        .fail   (fail),
        .cmd_if (cmd_if),
        .halted (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [3:0] exp);
        check($sformatf("%s@%0d", tag, edge_n), 32'({cmd_if.cmd_valid, cmd_if.cmd}), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic step_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic do_reset(input logic [3:0] lvl, input logic rdy);
        clrn  = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        up    = 1'b0;
        down  = 1'b0;
        fail  = 1'b0;
        level = lvl;
        cmd_if.cmd_ready = rdy;
        #1;
        check("reset_cmd", 32'({cmd_if.cmd_valid, cmd_if.cmd}), 32'(0));
        check("reset_halted", 32'(halted), 32'(0));
        @(negedge clk);
        clrn   = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        logic [3:0] exp;
        cmd_if.cmd_ready = 1'b1;

        // Gravity at level 0: first issue after edge 101, then every 100.
        do_reset(4'd0, 1'b1);
        for (int e = 1; e <= 305; e++) begin
            step();
            exp = (e == 101 || e == 201 || e == 301) ? 4'hD : 4'h0;
            check_cmd("grav_l0", exp);
        end

        // Single left pulse, then cancelled left+right pulse.
        do_reset(4'd0, 1'b1);
        step_to(9);
        left = 1'b1;
        step();
        left = 1'b0;
        check_cmd("left_pend", 4'h0);
        step();
        check_cmd("left_issue", 4'h9);
        step();
        check_cmd("left_done", 4'h0);
        step_to(19);
        left  = 1'b1;
        right = 1'b1;
        step();
        left  = 1'b0;
        right = 1'b0;
        for (int e = 21; e <= 25; e++) begin
            step();
            check_cmd("lr_cancel", 4'h0);
        end

        // Stalled rotate stays frozen across a gravity tick; then 3, 5, 1.
        do_reset(4'd0, 1'b0);
        step_to(9);
        up   = 1'b1;
        left = 1'b1;
        step();
        check_cmd("stall_pend", 4'h0);
        step();
        check_cmd("stall_rot", 4'hB);
        step_to(100);
        check_cmd("stall_tick", 4'hB);
        step_to(110);
        check_cmd("stall_hold", 4'hB);
        up   = 1'b0;
        left = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        step();
        check_cmd("order_gap1", 4'h0);
        step();
        check_cmd("order_grav", 4'hD);
        step();
        check_cmd("order_gap2", 4'h0);
        step();
        check_cmd("order_left", 4'h9);
        step();
        check_cmd("order_gap3", 4'h0);
        step();
        check_cmd("order_idle", 4'h0);

        // Reset in the middle of a stalled handshake drops cmd_valid at once.
        cmd_if.cmd_ready = 1'b0;
        step_to(119);
        up = 1'b1;
        step();
        step();
        check_cmd("midhs_valid", 4'hB);
        clrn = 1'b0;
        #1;
        check("midhs_reset", 32'(cmd_if.cmd_valid), 32'(0));

        // Level 15 clamps the period to 20.
        do_reset(4'd15, 1'b1);
        for (int e = 1; e <= 62; e++) begin
            step();
            exp = (e == 21 || e == 41 || e == 61) ? 4'hD : 4'h0;
            check_cmd("grav_l15", exp);
        end

        // Level 0 -> 8 at count 50: wraps at once, then period 20.
        do_reset(4'd0, 1'b1);
        step_to(50);
        level = 4'd8;
        for (int e = 51; e <= 93; e++) begin
            step();
            exp = (e == 52 || e == 72 || e == 92) ? 4'hD : 4'h0;
            check_cmd("grav_lvl8", exp);
        end

        // fail during a stalled issue: abort, halt, ignore everything after.
        do_reset(4'd0, 1'b0);
        step_to(9);
        up = 1'b1;
        step();
        up = 1'b0;
        step();
        check_cmd("fail_issue", 4'hB);
        step_to(15);
        fail = 1'b1;
        step();
        check_cmd("fail_abort", 4'h0);
        check("fail_halted", 32'(halted), 32'(1));
        fail = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        step_to(20);
        left = 1'b1;
        step();
        left = 1'b0;
        for (int e = 22; e <= 130; e++) begin
            step();
            check_cmd("halt_quiet", 4'h0);
        end
        check("halt_sticky", 32'(halted), 32'(1));

        // Hold right for 80 sampled edges (10..89).
        do_reset(4'd0, 1'b1);
        check("halt_cleared", 32'(halted), 32'(0));
        step_to(9);
        right = 1'b1;
        for (int e = 10; e <= 99; e++) begin
            step();
            if (edge_n == 89) right = 1'b0;
`ifdef AUTOREPEAT_EN
            exp = (e == 11 || e == 50 || e == 58 || e == 66 || e == 74 || e == 82 ||
                   e == 90) ? 4'hA : 4'h0;
`else
            exp = (e == 11) ? 4'hA : 4'h0;
`endif
            check_cmd("hold_right", exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
